// File: rtl/i2s_nos_bridge_pkg.sv
// i2s_nos_bridge_pkg
//   Shared types and helpers for the I2S to NOS DAC bridge.
//   - nos_bits_t : run-time output width select code
//   - tx_state_t : transmitter FSM states
//   - nos_width  : maps a width code to the number of bits shifted out
package i2s_nos_bridge_pkg;

  typedef enum logic [1:0] {
    NB_24 = 2'b00,
    NB_20 = 2'b01,
    NB_18 = 2'b10,
    NB_16 = 2'b11
  } nos_bits_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } tx_state_t;

  function automatic logic [4:0] nos_width(input nos_bits_t sel);
    logic [4:0] w;
    case (sel)
      NB_24:   w = 5'd24;
      NB_20:   w = 5'd20;
      NB_18:   w = 5'd18;
      NB_16:   w = 5'd16;
      default: w = 5'd24;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/i2s_nos_bridge_deframer.sv
// i2s_nos_bridge_deframer
//   Oversamples the asynchronous I2S lines, detects bck rises and splits the
//   serial stream into left/right words, MSB-aligned in OUT_MAX-bit registers.
//   Ports:
//     clk, reset                    logic clock, synchronous active-high reset
//     i2s_bck, i2s_lrck, i2s_data   asynchronous I2S inputs
//     l_word, r_word                last assembled left/right words
//     frame_valid                   one-clk pulse when a complete {L,R} pair ends
module i2s_nos_bridge_deframer
  import i2s_nos_bridge_pkg::*;
#(
  parameter int SLOT_MAX    = 32,
  parameter int OUT_MAX     = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i2s_bck,
  input  logic               i2s_lrck,
  input  logic               i2s_data,
  output logic [OUT_MAX-1:0] l_word,
  output logic [OUT_MAX-1:0] r_word,
  output logic               frame_valid
);

  localparam int IDX_W = $clog2(SLOT_MAX + 1);
  localparam int POS_W = (OUT_MAX > 1) ? $clog2(OUT_MAX) : 1;
  localparam logic [IDX_W-1:0] IDX_SAT = IDX_W'(SLOT_MAX);

  logic [SYNC_STAGES-1:0] bck_sync_r;
  logic [SYNC_STAGES-1:0] lr_sync_r;
  logic [SYNC_STAGES-1:0] dat_sync_r;
  logic                   bck_d_r;

  logic                   have_prev_r;  // at least one lrck sample taken
  logic                   lr_prev_r;    // channel owning the current bit
  logic                   synced_r;     // an lrck edge has been seen
  logic                   left_ok_r;    // a complete left word has ended
  logic                   new_word_r;   // next rise starts a fresh word
  logic [IDX_W-1:0]       idx_r;
  logic [OUT_MAX-1:0]     l_word_r;
  logic [OUT_MAX-1:0]     r_word_r;
  logic                   frame_valid_r;

  logic                   bck_s;
  logic                   lr_s;
  logic                   dat_s;
  logic                   rise_s;
  logic                   edge_s;
  logic                   keep_s;
  logic [IDX_W-1:0]       idx_eff_s;
  logic [IDX_W-1:0]       idx_next_s;
  logic [POS_W-1:0]       pos_s;
  logic [OUT_MAX-1:0]     cur_word_s;

  assign bck_s  = bck_sync_r[SYNC_STAGES-1];
  assign lr_s   = lr_sync_r[SYNC_STAGES-1];
  assign dat_s  = dat_sync_r[SYNC_STAGES-1];
  assign rise_s = bck_s & ~bck_d_r;

  // Synchroniser chains and bck edge-detect delay flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      bck_sync_r <= {SYNC_STAGES{1'b0}};
      lr_sync_r  <= {SYNC_STAGES{1'b0}};
      dat_sync_r <= {SYNC_STAGES{1'b0}};
      bck_d_r    <= 1'b0;
    end else begin
      bck_sync_r <= {bck_sync_r[SYNC_STAGES-2:0], i2s_bck};
      lr_sync_r  <= {lr_sync_r[SYNC_STAGES-2:0], i2s_lrck};
      dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], i2s_data};
      bck_d_r    <= bck_s;
    end
  end

  // Next word contents and bit index for the bit sampled on this rise.
  always_comb begin
    edge_s    = have_prev_r && (lr_s != lr_prev_r);
    idx_eff_s = new_word_r ? {IDX_W{1'b0}} : idx_r;
    keep_s    = synced_r && (int'(idx_eff_s) < OUT_MAX) && (int'(idx_eff_s) < SLOT_MAX);
    pos_s     = POS_W'(OUT_MAX - 1 - int'(idx_eff_s));
    if (idx_eff_s == IDX_SAT) begin
      idx_next_s = idx_eff_s;
    end else begin
      idx_next_s = idx_eff_s + {{(IDX_W-1){1'b0}}, 1'b1};
    end
    if (new_word_r) begin
      cur_word_s = {OUT_MAX{1'b0}};
    end else if (lr_prev_r) begin
      cur_word_s = r_word_r;
    end else begin
      cur_word_s = l_word_r;
    end
    if (keep_s) begin
      cur_word_s[pos_s] = dat_s;
    end else begin
      cur_word_s = cur_word_s;
    end
  end

  // Deframer state: updated only on a detected bck rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      have_prev_r   <= 1'b0;
      lr_prev_r     <= 1'b0;
      synced_r      <= 1'b0;
      left_ok_r     <= 1'b0;
      new_word_r    <= 1'b0;
      idx_r         <= {IDX_W{1'b0}};
      l_word_r      <= {OUT_MAX{1'b0}};
      r_word_r      <= {OUT_MAX{1'b0}};
      frame_valid_r <= 1'b0;
    end else if (rise_s) begin
      have_prev_r <= 1'b1;
      lr_prev_r   <= lr_s;
      idx_r       <= idx_next_s;
      if (lr_prev_r) begin
        r_word_r <= cur_word_s;
      end else begin
        l_word_r <= cur_word_s;
      end
      if (edge_s) begin
        // The bit on this rise was the LSB of the channel that just ended.
        new_word_r    <= 1'b1;
        synced_r      <= 1'b1;
        left_ok_r     <= left_ok_r | (synced_r & ~lr_prev_r);
        frame_valid_r <= synced_r & lr_prev_r & left_ok_r;
      end else begin
        new_word_r    <= 1'b0;
        frame_valid_r <= 1'b0;
      end
    end else begin
      frame_valid_r <= 1'b0;
    end
  end

  assign l_word      = l_word_r;
  assign r_word      = r_word_r;
  assign frame_valid = frame_valid_r;

endmodule

// File: rtl/i2s_nos_bridge.sv
// i2s_nos_bridge
//   I2S to parallel-latch NOS DAC bridge: deframer, 1-entry holding buffer and
//   a transmitter that shifts both words out on a shared bit clock followed by
//   a latch-enable pulse.
//   Ports:
//     clk, reset                    logic clock, synchronous active-high reset
//     i2s_bck, i2s_lrck, i2s_data   asynchronous I2S inputs
//     nos_bits                      width select: 00=24 01=20 10=18 11=16
//     mute                          send zero words
//     nos_bck, nos_le               DAC bit clock and latch enable
//     nos_data_l, nos_data_r        serial data, MSB first
//     busy                          transmitter not idle
//     overflow                      sticky: a frame pair was dropped
module i2s_nos_bridge
  import i2s_nos_bridge_pkg::*;
#(
  parameter int SLOT_MAX    = 32,
  parameter int OUT_MAX     = 24,
  parameter int CLK_DIV     = 2,
  parameter int LE_BCK      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2s_bck,
  input  logic       i2s_lrck,
  input  logic       i2s_data,
  input  logic [1:0] nos_bits,
  input  logic       mute,
  output logic       nos_bck,
  output logic       nos_le,
  output logic       nos_data_l,
  output logic       nos_data_r,
  output logic       busy,
  output logic       overflow
);

  localparam int LE_LEN = 2 * CLK_DIV * LE_BCK;
  localparam int TICK_W = $clog2(2 * CLK_DIV + 1);
  localparam int LE_W   = $clog2(LE_LEN + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(2 * CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_RISE = TICK_W'(CLK_DIV - 1);
  localparam logic [LE_W-1:0]   LE_LAST   = LE_W'(LE_LEN - 1);

  logic [OUT_MAX-1:0] l_word_s;
  logic [OUT_MAX-1:0] r_word_s;
  logic               frame_valid_s;

  logic               buf_full_r;
  logic [OUT_MAX-1:0] buf_l_r;
  logic [OUT_MAX-1:0] buf_r_r;
  logic               overflow_r;

  tx_state_t          state_r, state_n;
  logic [TICK_W-1:0]  tick_r, tick_n;
  logic [4:0]         bit_r, bit_n;
  logic [4:0]         width_r, width_n;
  logic [LE_W-1:0]    le_cnt_r, le_cnt_n;
  logic [OUT_MAX-1:0] sh_l_r, sh_l_n;
  logic [OUT_MAX-1:0] sh_r_r, sh_r_n;
  logic               bck_r, bck_n;
  logic               le_r, le_n;
  logic               dl_r, dl_n;
  logic               dr_r, dr_n;
  logic               busy_r, busy_n;
  logic               take_s;
  logic [OUT_MAX-1:0] word_l_s;
  logic [OUT_MAX-1:0] word_r_s;

  i2s_nos_bridge_deframer #(
    .SLOT_MAX    (SLOT_MAX),
    .OUT_MAX     (OUT_MAX),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deframer (
    .clk         (clk),
    .reset       (reset),
    .i2s_bck     (i2s_bck),
    .i2s_lrck    (i2s_lrck),
    .i2s_data    (i2s_data),
    .l_word      (l_word_s),
    .r_word      (r_word_s),
    .frame_valid (frame_valid_s)
  );

  // Holding buffer: a load in the same cycle as a take still lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full_r <= 1'b0;
      buf_l_r    <= {OUT_MAX{1'b0}};
      buf_r_r    <= {OUT_MAX{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (frame_valid_s && (!buf_full_r || take_s)) begin
        buf_l_r    <= l_word_s;
        buf_r_r    <= r_word_s;
        buf_full_r <= 1'b1;
      end else if (take_s) begin
        buf_full_r <= 1'b0;
      end else begin
        buf_full_r <= buf_full_r;
      end
      if (frame_valid_s && buf_full_r && !take_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Transmitter next-state and next-output logic.
  always_comb begin
    state_n  = state_r;
    tick_n   = tick_r;
    bit_n    = bit_r;
    width_n  = width_r;
    le_cnt_n = le_cnt_r;
    sh_l_n   = sh_l_r;
    sh_r_n   = sh_r_r;
    bck_n    = bck_r;
    le_n     = le_r;
    dl_n     = dl_r;
    dr_n     = dr_r;
    busy_n   = busy_r;
    take_s   = 1'b0;
    word_l_s = mute ? {OUT_MAX{1'b0}} : buf_l_r;
    word_r_s = mute ? {OUT_MAX{1'b0}} : buf_r_r;
    case (state_r)
      IDLE: begin
        bck_n = 1'b0;
        le_n  = 1'b0;
        dl_n  = 1'b0;
        dr_n  = 1'b0;
        if (buf_full_r) begin
          // Width and mute are frozen here for the whole frame.
          take_s  = 1'b1;
          width_n = nos_width(nos_bits_t'(nos_bits));
          dl_n    = word_l_s[OUT_MAX-1];
          dr_n    = word_r_s[OUT_MAX-1];
          sh_l_n  = {word_l_s[OUT_MAX-2:0], 1'b0};
          sh_r_n  = {word_r_s[OUT_MAX-2:0], 1'b0};
          bit_n   = 5'd0;
          tick_n  = {TICK_W{1'b0}};
          busy_n  = 1'b1;
          state_n = SHIFT;
        end else begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      SHIFT: begin
        busy_n = 1'b1;
        if (tick_r == TICK_LAST) begin
          bck_n  = 1'b0;
          tick_n = {TICK_W{1'b0}};
          if (bit_r == (width_r - 5'd1)) begin
            dl_n     = 1'b0;
            dr_n     = 1'b0;
            le_n     = 1'b1;
            le_cnt_n = {LE_W{1'b0}};
            state_n  = LATCH;
          end else begin
            // New data only appears together with the falling bck.
            bit_n  = bit_r + 5'd1;
            dl_n   = sh_l_r[OUT_MAX-1];
            dr_n   = sh_r_r[OUT_MAX-1];
            sh_l_n = {sh_l_r[OUT_MAX-2:0], 1'b0};
            sh_r_n = {sh_r_r[OUT_MAX-2:0], 1'b0};
          end
        end else begin
          tick_n = tick_r + {{(TICK_W-1){1'b0}}, 1'b1};
          bck_n  = (tick_r >= TICK_RISE);
        end
      end
      LATCH: begin
        bck_n = 1'b0;
        dl_n  = 1'b0;
        dr_n  = 1'b0;
        if (le_cnt_r == LE_LAST) begin
          le_n    = 1'b0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          le_cnt_n = le_cnt_r + {{(LE_W-1){1'b0}}, 1'b1};
          le_n     = 1'b1;
        end
      end
      default: begin
        bck_n   = 1'b0;
        le_n    = 1'b0;
        dl_n    = 1'b0;
        dr_n    = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // Transmitter state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      tick_r   <= {TICK_W{1'b0}};
      bit_r    <= 5'd0;
      width_r  <= 5'd0;
      le_cnt_r <= {LE_W{1'b0}};
      sh_l_r   <= {OUT_MAX{1'b0}};
      sh_r_r   <= {OUT_MAX{1'b0}};
      bck_r    <= 1'b0;
      le_r     <= 1'b0;
      dl_r     <= 1'b0;
      dr_r     <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      tick_r   <= tick_n;
      bit_r    <= bit_n;
      width_r  <= width_n;
      le_cnt_r <= le_cnt_n;
      sh_l_r   <= sh_l_n;
      sh_r_r   <= sh_r_n;
      bck_r    <= bck_n;
      le_r     <= le_n;
      dl_r     <= dl_n;
      dr_r     <= dr_n;
      busy_r   <= busy_n;
    end
  end

  assign nos_bck    = bck_r;
  assign nos_le     = le_r;
  assign nos_data_l = dl_r;
  assign nos_data_r = dr_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_i2s_nos_bridge.sv
// tb_i2s_nos_bridge
//   Directed bench: u_dut1 uses CLK_DIV=2, u_dut2 uses CLK_DIV=64 for the
//   overflow scenario. Both share the I2S stimulus; each has its own reset.
module tb_i2s_nos_bridge;

  logic       clk = 1'b0;
  logic       reset, rst2;
  logic       i2s_bck, i2s_lrck, i2s_data;
  logic [1:0] nos_bits;
  logic       mute;

  logic bck1, le1, dl1, dr1, busy1, ovf1;
  logic bck2, le2, dl2, dr2, busy2, ovf2;

  int n_cmp = 0;
  int n_err = 0;

  logic carry;
  logic lead_done;
  logic mon_clr = 1'b0;

  // monitor state (written only by the monitor processes)
  logic        bck1_p = 1'b0, le1_p = 1'b0, dl1_p = 1'b0, dr1_p = 1'b0;
  logic [31:0] cap_l1 = 32'd0, cap_r1 = 32'd0, last_l1 = 32'd0, last_r1 = 32'd0;
  int          cnt1 = 0, last_n1 = 0, frames1 = 0, le_run1 = 0, last_le1 = 0, viol1 = 0;
  logic        bck2_p = 1'b0, le2_p = 1'b0;
  logic [31:0] cap_l2 = 32'd0, cap_r2 = 32'd0, last_l2 = 32'd0, last_r2 = 32'd0;
  int          cnt2 = 0, last_n2 = 0, frames2 = 0;

  always #5 clk = ~clk;

  i2s_nos_bridge u_dut1 (
    .clk(clk), .reset(reset), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
    .nos_bits(nos_bits), .mute(mute), .nos_bck(bck1), .nos_le(le1),
    .nos_data_l(dl1), .nos_data_r(dr1), .busy(busy1), .overflow(ovf1)
  );

  i2s_nos_bridge #(.CLK_DIV(64)) u_dut2 (
    .clk(clk), .reset(rst2), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
    .nos_bits(nos_bits), .mute(mute), .nos_bck(bck2), .nos_le(le2),
    .nos_data_l(dl2), .nos_data_r(dr2), .busy(busy2), .overflow(ovf2)
  );

  // Capture bits on each nos_bck rise, snapshot a frame at each nos_le rise.
  always @(negedge clk) begin
    bck1_p <= bck1; le1_p <= le1; dl1_p <= dl1; dr1_p <= dr1;
    if (bck1 && bck1_p && ((dl1 != dl1_p) || (dr1 != dr1_p))) viol1 <= viol1 + 1;
    if (mon_clr) begin
      cap_l1 <= 32'd0; cap_r1 <= 32'd0; cnt1 <= 0;
    end else begin
      if (bck1 && !bck1_p) begin
        cap_l1 <= {cap_l1[30:0], dl1}; cap_r1 <= {cap_r1[30:0], dr1}; cnt1 <= cnt1 + 1;
      end
      if (le1 && !le1_p) begin
        last_l1 <= cap_l1; last_r1 <= cap_r1; last_n1 <= cnt1;
        cap_l1 <= 32'd0; cap_r1 <= 32'd0; cnt1 <= 0; frames1 <= frames1 + 1; le_run1 <= 1;
      end else if (le1) begin
        le_run1 <= le_run1 + 1;
      end
      if (!le1 && le1_p) last_le1 <= le_run1;
    end
  end

  // Same capture for the slow instance.
  always @(negedge clk) begin
    bck2_p <= bck2; le2_p <= le2;
    if (mon_clr) begin
      cap_l2 <= 32'd0; cap_r2 <= 32'd0; cnt2 <= 0;
    end else begin
      if (bck2 && !bck2_p) begin
        cap_l2 <= {cap_l2[30:0], dl2}; cap_r2 <= {cap_r2[30:0], dr2}; cnt2 <= cnt2 + 1;
      end
      if (le2 && !le2_p) begin
        last_l2 <= cap_l2; last_r2 <= cap_r2; last_n2 <= cnt2;
        cap_l2 <= 32'd0; cap_r2 <= 32'd0; cnt2 <= 0; frames2 <= frames2 + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bck period: lrck/data change with the falling bck, 8 clk low, 8 clk high.
  task automatic bck_cycle(input logic lr, input logic d);
    i2s_bck = 1'b0; i2s_lrck = lr; i2s_data = d;
    repeat (8) @(posedge clk);
    #1 i2s_bck = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Stereo frame, words left-aligned in lv/rv, n bck per slot, data one bck late.
  task automatic send_frame(input logic [31:0] lv, input logic [31:0] rv, input int n);
    if (!lead_done) bck_cycle(1'b0, carry);
    for (int i = 0; i < n - 1; i++) bck_cycle(1'b0, lv[31-i]);
    bck_cycle(1'b1, lv[32-n]);
    for (int i = 0; i < n - 1; i++) bck_cycle(1'b1, rv[31-i]);
    carry = rv[32-n];
    lead_done = 1'b0;
  endtask

  // Ends the right word (its LSB on this rise) and leaves bck high.
  task automatic flush();
    i2s_bck = 1'b0; i2s_lrck = 1'b0; i2s_data = carry;
    repeat (8) @(posedge clk);
    #1 i2s_bck = 1'b1;
    lead_done = 1'b1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wait_done1(input int target, input int budget, input string tag);
    int n = 0;
    while (((frames1 < target) || busy1) && (n < budget)) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_timeout"}, 32'(n >= budget), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy1(input string tag);
    int n = 0;
    while (!busy1 && (n < 200)) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_busy_timeout"}, 32'(n >= 200), 32'd0);
  endtask

  initial begin
    int lat;
    int fb;
    int n;
    reset = 1'b1; rst2 = 1'b1;
    i2s_bck = 1'b0; i2s_lrck = 1'b0; i2s_data = 1'b0;
    nos_bits = 2'b00; mute = 1'b0;
    carry = 1'b0; lead_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs1", {26'd0, bck1, le1, dl1, dr1, busy1, ovf1}, 32'd0);
    check("reset_outs2", {26'd0, bck2, le2, dl2, dr2, busy2, ovf2}, 32'd0);
    reset = 1'b0; rst2 = 1'b0;

    // 1: 24-bit words in 32-bit slots, preceded by a sync frame that is not output
    send_frame(32'h11111100, 32'h22222200, 32);
    send_frame(32'hA5A5A500, 32'h3C3C3C00, 32);
    flush();
    lat = 0;
    while (!busy1 && (lat < 50)) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, 32'd5);
    wait_done1(1, 2000, "t1");
    check("t1_rises", last_n1, 32'd24);
    check("t1_left", last_l1, 32'h00A5A5A5);
    check("t1_right", last_r1, 32'h003C3C3C);
    check("t1_le_len", last_le1, 32'd4);
    check("t1_frames", frames1, 32'd1);
    check("t1_ovf", {31'd0, ovf1}, 32'd0);

    // 2: truncation to 16 bits; width change mid-frame must not matter
    nos_bits = 2'b11;
    send_frame(32'h12345600, 32'hFEDCBA00, 32);
    flush();
    wait_busy1("t2");
    nos_bits = 2'b00;
    wait_done1(2, 2000, "t2");
    check("t2_rises", last_n1, 32'd16);
    check("t2_left", last_l1, 32'h00001234);
    check("t2_right", last_r1, 32'h0000FEDC);

    // 3: 16-bit slots zero-padded to 24 bits
    send_frame(32'hBEEF0000, 32'h00010000, 16);
    flush();
    wait_done1(3, 2000, "t3");
    check("t3_rises", last_n1, 32'd24);
    check("t3_left", last_l1, 32'h00BEEF00);
    check("t3_right", last_r1, 32'h00000100);

    // 4: mute sends zeros but still latches
    mute = 1'b1;
    send_frame(32'hFFFFFF00, 32'hFFFFFF00, 32);
    flush();
    wait_busy1("t4");
    mute = 1'b0;
    wait_done1(4, 2000, "t4");
    check("t4_rises", last_n1, 32'd24);
    check("t4_left", last_l1, 32'd0);
    check("t4_right", last_r1, 32'd0);
    check("t4_le_len", last_le1, 32'd4);

    // 5: overflow on the slow instance
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    clear_mon();
    fb = frames2;
    send_frame(32'h01020300, 32'h04050600, 32);
    send_frame(32'hC3A50F00, 32'h96E1D200, 32);
    send_frame(32'h55AA5500, 32'hAA55AA00, 32);
    send_frame(32'h0F0F0F00, 32'hF0F0F000, 32);
    check("t5_ovf_before", {31'd0, ovf2}, 32'd0);
    flush();
    repeat (10) @(posedge clk);
    #1;
    check("t5_ovf_set", {31'd0, ovf2}, 32'd1);
    n = 0;
    while ((frames2 < fb + 1) && (n < 6000)) begin
      @(posedge clk); #1; n++;
    end
    check("t5_frame_timeout", 32'(n >= 6000), 32'd0);
    check("t5_rises", last_n2, 32'd24);
    check("t5_left", last_l2, 32'h00C3A50F);
    check("t5_right", last_r2, 32'h0096E1D2);
    n = 0;
    while (busy2 && (n < 8000)) begin
      @(posedge clk); #1; n++;
    end
    check("t5_idle_timeout", 32'(n >= 8000), 32'd0);
    check("t5_ovf_held", {31'd0, ovf2}, 32'd1);
    check("t5_ovf_fast", {31'd0, ovf1}, 32'd0);

    // 6: reset in the middle of a shifted frame
    send_frame(32'h0F0F0F00, 32'h71717100, 32);
    flush();
    n = 0;
    while ((cnt1 < 10) && (n < 500)) begin
      @(posedge clk); #1; n++;
    end
    check("t6_shift_timeout", 32'(n >= 500), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("t6_outs_zero", {26'd0, bck1, le1, dl1, dr1, busy1, ovf1}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
    fb = frames1;
    for (int i = 0; i < 10; i++) bck_cycle(1'b1, 1'b1);
    carry = 1'b1; lead_done = 1'b0;
    send_frame(32'h13579B00, 32'h2468AC00, 32);
    flush();
    wait_done1(fb + 1, 2000, "t6");
    repeat (200) @(posedge clk);
    #1;
    check("t6_frames", frames1 - fb, 32'd1);
    check("t6_left", last_l1, 32'h0013579B);
    check("t6_right", last_r1, 32'h002468AC);
    check("data_stable_high", viol1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
